// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with pending scoreboard and clear sequencer (REGFILE_BYPASS_EN enables same-cycle write forwarding)
module regfile_param #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rpend,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                alloc,
    input  logic [AW-1:0]       alloc_addr,
    output logic                init_busy
);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    localparam logic [AW:0] LAST = (AW + 1)'(NREGS - 1);

    state_t          state;
    state_t          state_nxt;
    logic [AW:0]     cnt;
    logic [AW:0]     cnt_nxt;
    logic [XLEN-1:0] mem [NREGS];
    logic [NREGS-1:0] pend;

    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [XLEN-1:0] mem_wd;
    logic            run_we;
    logic            run_alloc;

    // Entry 0 is architecturally constant when ZERO_REG is set
    function automatic logic is_zero(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign run_we    = (state == S_RUN) && we && !is_zero(wa);
    assign run_alloc = (state == S_RUN) && alloc && !is_zero(alloc_addr);
    assign init_busy = (state == S_INIT);

    // Sequencer state and clear counter; reset restarts the clear from entry 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and storage write port: the sequencer owns the port during INIT
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_wa    = wa;
        mem_wd    = wd;
        case (state)
            S_INIT: begin
                mem_we  = 1'b1;
                mem_wa  = cnt[AW-1:0];
                mem_wd  = '0;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                mem_we = run_we;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    // Register storage; contents are defined only once the sequencer has swept them
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Pending scoreboard; the alloc assignment comes last so a same-edge alloc wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            if (run_we) begin
                pend[wa] <= 1'b0;
            end
            if (run_alloc) begin
                pend[alloc_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports, optionally forwarding the in-flight write
    always_comb begin
        logic [AW-1:0] addr;
        addr  = '0;
        rd    = '0;
        rpend = '0;
        if (state == S_RUN) begin
            for (int i = 0; i < NRD; i++) begin
                addr = ra[i*AW +: AW];
                if (!is_zero(addr)) begin
                    rd[i*XLEN +: XLEN] = mem[addr];
                    rpend[i]           = pend[addr];
`ifdef REGFILE_BYPASS_EN
                    if (run_we && (wa == addr)) begin
                        rd[i*XLEN +: XLEN] = wd;
                        rpend[i]           = 1'b0;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - randomized model-checked bench for regfile_param (default and 64x16x3 configurations)
module tb_regfile_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]   ra_a;
    logic [63:0]  rd_a;
    logic [1:0]   rpend_a;
    logic         we_a;
    logic [4:0]   wa_a;
    logic [31:0]  wd_a;
    logic         alloc_a;
    logic [4:0]   aa_a;
    logic         busy_a;

    logic [11:0]  ra_b;
    logic [191:0] rd_b;
    logic [2:0]   rpend_b;
    logic         we_b;
    logic [3:0]   wa_b;
    logic [63:0]  wd_b;
    logic         alloc_b;
    logic [3:0]   aa_b;
    logic         busy_b;

    regfile_param #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .ra(ra_a), .rd(rd_a), .rpend(rpend_a),
        .we(we_a), .wa(wa_a), .wd(wd_a), .alloc(alloc_a), .alloc_addr(aa_a),
        .init_busy(busy_a)
    );

    regfile_param #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .ra(ra_b), .rd(rd_b), .rpend(rpend_b),
        .we(we_b), .wa(wa_b), .wd(wd_b), .alloc(alloc_b), .alloc_addr(aa_b),
        .init_busy(busy_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: clear countdown, architectural contents and pending flags
    logic [31:0] ma [32];
    bit          pa [32];
    int          ca;
    logic [63:0] mb [16];
    bit          pb [16];
    int          cb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ca = 32;
            cb = 16;
            for (int i = 0; i < 32; i++) begin ma[i] = '0; pa[i] = 0; end
            for (int i = 0; i < 16; i++) begin mb[i] = '0; pb[i] = 0; end
        end else begin
            if (ca > 0) ca--;
            else begin
                if (we_a && wa_a != 0) begin ma[wa_a] = wd_a; pa[wa_a] = 0; end
                if (alloc_a && aa_a != 0) pa[aa_a] = 1;
            end
            if (cb > 0) cb--;
            else begin
                if (we_b) begin mb[wa_b] = wd_b; pb[wa_b] = 0; end
                if (alloc_b) pb[aa_b] = 1;
            end
        end
    end

    function automatic logic [31:0] exp_rd_a(input int i);
        logic [4:0] a;
        a = ra_a[i*5 +: 5];
        if (ca > 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we_a && wa_a == a) return wd_a;
`endif
        return ma[a];
    endfunction

    function automatic logic exp_rp_a(input int i);
        logic [4:0] a;
        a = ra_a[i*5 +: 5];
        if (ca > 0 || a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we_a && wa_a == a) return 1'b0;
`endif
        return pa[a];
    endfunction

    function automatic logic [63:0] exp_rd_b(input int i);
        logic [3:0] a;
        a = ra_b[i*4 +: 4];
        if (cb > 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we_b && wa_b == a) return wd_b;
`endif
        return mb[a];
    endfunction

    function automatic logic exp_rp_b(input int i);
        logic [3:0] a;
        a = ra_b[i*4 +: 4];
        if (cb > 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we_b && wa_b == a) return 1'b0;
`endif
        return pb[a];
    endfunction

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("busy_a", busy_a, ca > 0);
        chk("busy_b", busy_b, cb > 0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rd_a%0d", i), rd_a[i*32 +: 32], exp_rd_a(i));
            chk($sformatf("rpend_a%0d", i), rpend_a[i], exp_rp_a(i));
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd_b%0d", i), rd_b[i*64 +: 64], exp_rd_b(i));
            chk($sformatf("rpend_b%0d", i), rpend_b[i], exp_rp_b(i));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        we_a = 0; wa_a = 0; wd_a = 0; alloc_a = 0; aa_a = 0; ra_a = 0;
        we_b = 0; wa_b = 0; wd_b = 0; alloc_b = 0; aa_b = 0; ra_b = 0;
        #12;
        chk("rst_busy_a", busy_a, 1);
        chk("rst_busy_b", busy_b, 1);
        chk("rst_rpend_a", rpend_a, 0);
        chk("rst_rd_a", rd_a, 0);

        // Clear latency with a write attempt during INIT
        step();
        rst = 0;
        we_a = 1; wa_a = 5; wd_a = 32'hDEAD; ra_a = {5'd5, 5'd5};
        repeat (15) step();
        chk("clr_b_15", busy_b, 1);
        step();
        chk("clr_b_16", busy_b, 0);
        repeat (15) step();
        chk("clr_a_31", busy_a, 1);
        step();
        chk("clr_a_32", busy_a, 0);
        we_a = 0;
        #1 chk("x5_after_init", rd_a[31:0], 0);

        // Write then read on two ports
        we_a = 1; wa_a = 7; wd_a = 32'h12345678; ra_a = {5'd7, 5'd7};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x7_bypass_p0", rd_a[31:0], 32'h12345678);
        chk("x7_bypass_p1", rd_a[63:32], 32'h12345678);
`else
        chk("x7_nobypass_p0", rd_a[31:0], 0);
`endif
        step();
        we_a = 0;
        #1;
        chk("x7_p0", rd_a[31:0], 32'h12345678);
        chk("x7_p1", rd_a[63:32], 32'h12345678);

        // Zero register
        we_a = 1; wa_a = 0; wd_a = 32'hFFFFFFFF; alloc_a = 1; aa_a = 0; ra_a = 0;
        #1 chk("x0_same_cycle", rd_a[31:0], 0);
        step();
        we_a = 0; alloc_a = 0;
        #1;
        chk("x0_rd", rd_a[31:0], 0);
        chk("x0_rpend", rpend_a[0], 0);

        // Scoreboard
        alloc_a = 1; aa_a = 3; ra_a = {5'd3, 5'd3};
        step();
        alloc_a = 0;
        #1 chk("x3_pend_set", rpend_a[0], 1);
        step();
        step();
        we_a = 1; wa_a = 3; wd_a = 32'hA5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x3_pend_bypass", rpend_a[1], 0);
`else
        chk("x3_pend_hold", rpend_a[1], 1);
`endif
        step();
        we_a = 0;
        #1;
        chk("x3_pend_clr", rpend_a[0], 0);
        chk("x3_data", rd_a[31:0], 32'hA5);
        we_a = 1; wa_a = 3; wd_a = 32'hA5; alloc_a = 1; aa_a = 3;
        step();
        we_a = 0; alloc_a = 0;
        #1;
        chk("x3_alloc_wins", rpend_a[0], 1);
        chk("x3_data_kept", rd_a[31:0], 32'hA5);

        // Wide configuration: x0 stored, three distinct ports
        we_b = 1; wa_b = 0; wd_b = 64'h0123456789ABCDEF;
        step();
        wa_b = 1; wd_b = 64'hFEDCBA9876543210;
        step();
        wa_b = 2; wd_b = 64'h5555AAAA5555AAAA;
        step();
        we_b = 0; ra_b = {4'd2, 4'd1, 4'd0};
        #1;
        chk("b_x0", rd_b[63:0], 64'h0123456789ABCDEF);
        chk("b_x1", rd_b[127:64], 64'hFEDCBA9876543210);
        chk("b_x2", rd_b[191:128], 64'h5555AAAA5555AAAA);

        // Asynchronous reset mid-RUN with x9 pending
        alloc_a = 1; aa_a = 9; ra_a = {5'd9, 5'd9};
        step();
        alloc_a = 0;
        #1 chk("x9_pend", rpend_a[0], 1);
        #1 rst = 1;
        #1;
        chk("async_rpend", rpend_a, 0);
        chk("async_busy", busy_a, 1);
        step();
        rst = 0;
        repeat (10) step();
        rst = 1;
        step();
        rst = 0;
        repeat (31) step();
        chk("restart_31", busy_a, 1);
        step();
        chk("restart_32", busy_a, 0);

        // Randomized traffic, narrow address range to force collisions
        for (int n = 0; n < 3000; n++) begin
            we_a    = ($urandom_range(0, 2) != 0);
            wa_a    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wd_a    = $urandom;
            alloc_a = ($urandom_range(0, 2) == 0);
            aa_a    = 5'($urandom_range(0, 7));
            ra_a    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            we_b    = ($urandom_range(0, 1) != 0);
            wa_b    = 4'($urandom);
            wd_b    = {$urandom, $urandom};
            alloc_b = ($urandom_range(0, 2) == 0);
            aa_b    = 4'($urandom);
            ra_b    = {4'($urandom), 4'($urandom), 4'($urandom)};
            if (n == 1500) begin
                #2 rst = 1;
                step();
                rst = 0;
            end else begin
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised integer register file with configurable width, depth and read-port count, a per-register pending scoreboard, and a hardware clear sequencer. It replaces the fixed 32x32, 2-read-port register file in the decode stage. It also feeds the hazard unit with pending flags, so the hazard unit no longer recomputes destination matches across the pipeline.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2. AW = $clog2(NREGS).
- NRD, 2, number of read ports, 1 to 4.
- ZERO_REG, 1, when 1 entry 0 is hardwired: reads 0, never written, never pending.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ra  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd  out  NRD*XLEN  packed read data; combinational from ra.
- rpend  out  NRD  per-port pending flag for the addressed register; combinational.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- alloc  in  1  mark register alloc_addr pending (destination of an issued instruction).
- alloc_addr  in  AW  register to mark pending.
- init_busy  out  1  clear sequencer active; reset value 1.

## Operation
- Storage: NREGS x XLEN flops plus NREGS pending bits. There is a sequencer counter of width AW+1.
- States: INIT and RUN.
  - rst asserted: go to INIT, set counter to 0, clear all pending bits.
  - INIT: each cycle write 0 to entry counter, then increment the counter. After the write of entry NREGS-1, go to RUN.
  - RUN: normal operation; stays in RUN until the next reset.
- While in INIT:
  - rd = 0 and rpend = 0 on all ports.
  - we and alloc are ignored and not buffered.
- In RUN:
  - Write: on a clock edge with we=1, entry wa <= wd and pending[wa] <= 0. Skipped for wa=0 when ZERO_REG=1.
  - Alloc: on a clock edge with alloc=1, pending[alloc_addr] <= 1. Ignored for alloc_addr=0 when ZERO_REG=1.
  - Same-cycle write and alloc to the same address: data is written and pending ends at 1. The alloc belongs to the newer instruction and wins.
  - Read port i: rd[i] = entry ra[i]; rpend[i] = pending[ra[i]]. Address 0 with ZERO_REG=1 returns 0 and rpend=0.
  - With bypass enabled (see Configuration): if we=1 and wa==ra[i] (and not the zero register), rd[i] = wd and rpend[i] = 0 in the same cycle.
- Multiple read ports may address the same entry; each port is independent.

## Timing
- Reset values:
  - rd = 0 and rpend = 0 on all ports.
  - init_busy = 1.
  - All pending bits = 0.
  - Storage contents are undefined until the sequencer has cleared them.
- Clear latency: init_busy falls exactly NREGS rising edges after rst deasserts. First RUN-state write is accepted on the following edge.
- Reset asserted mid-INIT restarts the sequence from entry 0. Reset asserted mid-RUN discards all pending bits immediately (asynchronous).
- Read latency: 0 cycles, combinational.
- Write-to-read visibility: the cycle after the write edge without bypass; the same cycle with bypass.
- Pending set by alloc is visible on rpend the cycle after the alloc edge.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding as described in Operation. The decode stage needs no half-cycle write.
- REGFILE_BYPASS_EN undefined: no forwarding; reads return stored contents only. Register-file write-then-read in the same cycle is a hazard that the hazard unit handles.

## Test plan
- Reset and clear: NREGS=32. Release rst; init_busy stays 1 for exactly 32 edges. we=1, wa=5, wd=0xDEAD during INIT is ignored. After INIT, reading x5 returns 0.
- Write/read: in RUN, write 0x12345678 to x7, then read on port 0 and port 1 together.
  - Next cycle both ports return 0x12345678.
  - With REGFILE_BYPASS_EN, the value appears in the write cycle.
- Zero register: write 0xFFFFFFFF to x0 and alloc x0. Reading x0 gives rd=0 and rpend=0.
- Scoreboard: alloc x3, then rpend=1 for ra=3. Write x3=0xA5 three cycles later; rpend drops to 0 the next cycle. Same-edge write and alloc on x3 leaves rpend=1 with data 0xA5.
- Reset mid-operation:
  - With x9 pending, assert rst asynchronously between edges; rpend clears and init_busy rises without waiting for a clock edge.
  - Reassert rst after 10 INIT cycles; the clear restarts and runs a full 32 cycles.
- Parameter sweep: XLEN=64, NREGS=16, NRD=3, ZERO_REG=0.
  - Write to x0 is stored.
  - Three ports read distinct registers correctly.
  - Clear takes 16 cycles.
